// File: rtl/lfsr_msg_decoder.sv
// LFSR message decoder: learns the scrambler tap from a known preamble, then
// descrambles the payload. Build macro PARITY_CHECK_EN enables payload parity checking.
module lfsr_msg_decoder #(
    parameter int unsigned PREAMBLE_LEN = 4,
    parameter logic [6:0]  PAD_CHAR     = 7'h20,
    parameter logic [55:0] TAP_TABLE    = {7'h7E, 7'h5C, 7'h69, 7'h6A, 7'h72, 7'h78, 7'h48, 7'h60}
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       start_i,
    input  logic       in_valid_i,
    input  logic [7:0] in_data_i,
    input  logic       in_last_i,
    output logic       in_ready_o,
    output logic       out_valid_o,
    output logic [7:0] out_data_o,
    input  logic       out_ready_i,
    output logic [2:0] tap_idx_o,
    output logic       done_o,
    output logic       error_o,
    output logic       parity_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEED     = 2'd1,
        ST_PREAMBLE = 2'd2,
        ST_PAYLOAD  = 2'd3
    } state_e;

    localparam logic [3:0] LAST_CNT = 4'(PREAMBLE_LEN - 1);

    state_e     state_q, state_d;
    logic [6:0] lfsr_q, lfsr_d;
    logic [7:0] cand_q, cand_d;
    logic [3:0] pre_cnt_q, pre_cnt_d;
    logic [2:0] tap_idx_q, tap_idx_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_data_q, out_data_d;
    logic       done_q, done_d;
    logic       error_q, error_d;
    logic       perr_q, perr_d;

    logic       in_ready;
    logic       accept;
    logic [6:0] taps [8];
    logic [6:0] seen_state;
    logic [7:0] tap_match;
    logic [7:0] cand_next;
    logic [2:0] low_idx;
    logic       pre_final;
    logic       byte_perr;
    logic [6:0] pay_next;
    logic [6:0] tap_next;

    // Each preamble byte reveals the full LFSR state, so every candidate tap
    // can be tested against the transition from the previous state.
    assign seen_state = in_data_i[6:0] ^ PAD_CHAR;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_tap
            assign taps[gi]      = TAP_TABLE[gi*7 +: 7];
            assign tap_match[gi] = ({lfsr_q[5:0], ^(taps[gi] & lfsr_q)} == seen_state);
        end
    endgenerate

    assign cand_next = cand_q & tap_match;
    assign pre_final = (pre_cnt_q == LAST_CNT);

    always_comb begin
        low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (cand_next[i]) begin
                low_idx = 3'(i);
            end
        end
    end

    assign tap_next = {seen_state[5:0], ^(taps[low_idx] & seen_state)};
    assign pay_next = {lfsr_q[5:0], ^(taps[tap_idx_q] & lfsr_q)};

`ifdef PARITY_CHECK_EN
    assign byte_perr = in_data_i[7] ^ (^in_data_i[6:0]);
`else
    logic unused_parity_bit;
    assign unused_parity_bit = in_data_i[7];
    assign byte_perr         = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_SEED;
                end
            end
            ST_SEED: begin
                if (accept) begin
                    state_d = in_last_i ? ST_IDLE : ST_PREAMBLE;
                end
            end
            ST_PREAMBLE: begin
                if (accept) begin
                    if (in_last_i || (pre_final && (cand_next == 8'h00))) begin
                        state_d = ST_IDLE;
                    end else if (pre_final) begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (accept && in_last_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: a free or draining output slot lets a byte in
    always_comb begin
        in_ready = (state_q != ST_IDLE) && (!out_valid_q || out_ready_i);
        accept   = in_valid_i && in_ready;
    end

    always_comb begin
        lfsr_d      = lfsr_q;
        cand_d      = cand_q;
        pre_cnt_d   = pre_cnt_q;
        tap_idx_d   = tap_idx_q;
        out_valid_d = out_valid_q && !out_ready_i;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        error_d     = error_q;
        perr_d      = perr_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    error_d   = 1'b0;
                    perr_d    = 1'b0;
                    tap_idx_d = 3'd0;
                    cand_d    = 8'hFF;
                    pre_cnt_d = 4'd0;
                end
            end
            ST_SEED: begin
                if (accept) begin
                    if (in_last_i) begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        lfsr_d    = seen_state;
                        pre_cnt_d = 4'd1;
                    end
                end
            end
            ST_PREAMBLE: begin
                if (accept) begin
                    if (in_last_i) begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        cand_d    = cand_next;
                        lfsr_d    = seen_state;
                        pre_cnt_d = pre_cnt_q + 4'd1;
                        if (pre_final) begin
                            if (cand_next == 8'h00) begin
                                error_d = 1'b1;
                                done_d  = 1'b1;
                            end else begin
                                // Payload starts one step past the last preamble state
                                tap_idx_d = low_idx;
                                lfsr_d    = tap_next;
                            end
                        end
                    end
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_data_d  = {byte_perr, in_data_i[6:0] ^ lfsr_q};
                    lfsr_d      = pay_next;
                    if (byte_perr) begin
                        perr_d = 1'b1;
                    end
                    if (in_last_i) begin
                        done_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lfsr_q      <= 7'd0;
            cand_q      <= 8'hFF;
            pre_cnt_q   <= 4'd0;
            tap_idx_q   <= 3'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'd0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            lfsr_q      <= lfsr_d;
            cand_q      <= cand_d;
            pre_cnt_q   <= pre_cnt_d;
            tap_idx_q   <= tap_idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            error_q     <= error_d;
            perr_q      <= perr_d;
        end
    end

    assign in_ready_o   = in_ready;
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign tap_idx_o    = tap_idx_q;
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign parity_err_o = perr_q;

endmodule

// File: tb/tb_lfsr_msg_decoder.sv
// Self-checking bench for lfsr_msg_decoder: directed cases plus randomized messages
// checked against a message-level reference model (encoder + tap search).
module tb_lfsr_msg_decoder;

    localparam int         PRE_LEN = 4;
    localparam logic [6:0] PAD     = 7'h20;
    localparam int         CYC_MAX = 400;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [2:0] tap_idx;
    logic       done;
    logic       error;
    logic       parity_err;

    always #5 clk = ~clk;

    lfsr_msg_decoder #(.PREAMBLE_LEN(PRE_LEN), .PAD_CHAR(PAD)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .start_i     (start),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_ready_i (out_ready),
        .tap_idx_o   (tap_idx),
        .done_o      (done),
        .error_o     (error),
        .parity_err_o(parity_err)
    );

    logic [6:0] taps [8] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E};

    int         compared   = 0;
    int         mismatched = 0;
    string      cur_tag;
    logic [7:0] msg[$];
    logic [7:0] plain_q[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         exp_tap;
    int         exp_consumed;
    bit         exp_err;
    bit         exp_perr;
    bit         exp_normal;
    int         done_cnt;
    logic       done_ov;
    bit         prev_stall;
    logic [7:0] prev_data;
    logic [7:0] g0;
    logic [7:0] g1;
    int         r_len;
    int         r_lp;
    int         r_pci;
    logic [6:0] r_px;
    int         r_pfi;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s.%s: observed %0h expected %0h", cur_tag, name, got, exp);
        end
    endtask

    function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] tap);
        return {s[5:0], ^(s & tap)};
    endfunction

    // Encoder: PRE_LEN pad bytes then plain_q, each byte {parity(enc), plain ^ state}
    task automatic make_msg(input logic [6:0] seed, input int tap, input int pci,
                            input logic [6:0] pxor, input int pfi);
        logic [6:0] s;
        logic [6:0] e;
        logic [7:0] b;
        msg.delete();
        s = seed;
        for (int k = 0; k < PRE_LEN; k++) begin
            e = PAD ^ s;
            if (k == pci) e = e ^ pxor;
            msg.push_back({^e, e});
            s = lfsr_step(s, taps[tap]);
        end
        for (int i = 0; i < plain_q.size(); i++) begin
            b = plain_q[i];
            e = b[6:0] ^ s;
            b = {^e, e};
            if (i == pfi) b[7] = ~b[7];
            msg.push_back(b);
            s = lfsr_step(s, taps[tap]);
        end
    endtask

    // Reference: search the tap table for the first tap whose sequence from the
    // seed reproduces every observed preamble state, then descramble.
    task automatic model(input int last_pos);
        logic [6:0] st[$];
        logic [6:0] s;
        logic [7:0] b;
        logic       pb;
        bit         ok;
        bit         found;
        exp_q.delete();
        exp_err    = 1'b0;
        exp_perr   = 1'b0;
        exp_tap    = 0;
        exp_normal = 1'b0;
        if (last_pos < PRE_LEN) begin
            exp_err      = 1'b1;
            exp_consumed = last_pos + 1;
            return;
        end
        for (int k = 0; k < PRE_LEN; k++) begin
            b = msg[k];
            st.push_back(b[6:0] ^ PAD);
        end
        found = 1'b0;
        for (int t = 0; t < 8; t++) begin
            s  = st[0];
            ok = 1'b1;
            for (int k = 1; k < PRE_LEN; k++) begin
                s = lfsr_step(s, taps[t]);
                if (s != st[k]) ok = 1'b0;
            end
            if (ok && !found) begin
                found   = 1'b1;
                exp_tap = t;
            end
        end
        if (!found) begin
            exp_err      = 1'b1;
            exp_consumed = PRE_LEN;
            return;
        end
        s = lfsr_step(st[PRE_LEN-1], taps[exp_tap]);
        for (int k = PRE_LEN; k <= last_pos; k++) begin
            b = msg[k];
`ifdef PARITY_CHECK_EN
            pb = b[7] ^ (^b[6:0]);
`else
            pb = 1'b0;
`endif
            exp_q.push_back({pb, b[6:0] ^ s});
            exp_perr = exp_perr | pb;
            s = lfsr_step(s, taps[exp_tap]);
        end
        exp_consumed = last_pos + 1;
        exp_normal   = 1'b1;
    endtask

    task automatic sample();
        if (prev_stall) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, prev_data);
        end
        if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
        if (out_valid && out_ready) got_q.push_back(out_data);
        if (done) begin
            done_cnt++;
            done_ov = out_valid;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
    endtask

    // mode: 0 always ready, 1 random ready, 2 hold first output bp cycles, 3 never ready
    task automatic feed(input int n, input int last_pos, input int mode, input int bp, input bit gaps);
        int idx;
        int cyc;
        int bpl;
        bit acc;
        idx = 0;
        cyc = 0;
        bpl = bp;
        while (idx < n && cyc < CYC_MAX) begin
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = msg[idx];
            in_last  = (idx == last_pos);
            start    = gaps ? ($urandom_range(0, 7) == 0) : 1'b0;
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (out_valid && bpl > 0) begin
                        out_ready = 1'b0;
                        bpl--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b0;
            endcase
            @(negedge clk);
            sample();
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;
        check("feed_bound", (cyc < CYC_MAX) ? 1 : 0, 1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            sample();
            if (!out_valid && done_cnt > 0) break;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_msg(input string tag, input int last_pos, input int mode, input int bp, input bit gaps);
        logic [7:0] g;
        cur_tag = tag;
        model(last_pos);
        got_q.delete();
        done_cnt   = 0;
        done_ov    = 1'b0;
        prev_stall = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        feed(exp_consumed, last_pos, mode, bp, gaps);
        drain();
        check("out_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            check($sformatf("byte%0d", i), g, exp_q[i]);
        end
        check("done_count", done_cnt, 1);
        check("done_with_byte", done_ov, exp_normal);
        check("error", error, exp_err);
        check("parity_err", parity_err, exp_perr);
        check("tap_idx", tap_idx, exp_tap);
        g0 = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        g1 = (got_q.size() > 1) ? got_q[1] : 8'hxx;
        $display("msg %s: sent=%0d out=%0d tap=%0d err=%0d perr=%0d", tag, exp_consumed,
                 got_q.size(), tap_idx, error, parity_err);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b1;
        cur_tag   = "reset";
        #2;
        check("in_ready", in_ready, 0);
        check("out_valid", out_valid, 0);
        check("out_data", out_data, 0);
        check("tap_idx", tap_idx, 0);
        check("done", done, 0);
        check("error", error, 0);
        check("parity_err", parity_err, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", in_ready, 0);

        // Nominal message "HI", seed 41, tap 3
        plain_q = '{8'h48, 8'h49};
        make_msg(7'h41, 3, -1, 7'h00, -1);
        run_msg("t2", PRE_LEN + 1, 0, 0, 1'b0);
        check("t2_tap", tap_idx, 3);
        check("t2_b0", g0, 8'h48);
        check("t2_b1", g1, 8'h49);

        // Backpressure on the first output byte
        run_msg("t3", PRE_LEN + 1, 2, 3, 1'b0);
        check("t3_b0", g0, 8'h48);
        check("t3_b1", g1, 8'h49);

        // Bit 6 of preamble state 2 broken: no tap can predict it
        make_msg(7'h41, 3, 2, 7'h40, -1);
        run_msg("t4", PRE_LEN + 1, 0, 0, 1'b0);
        check("t4_error", error, 1);

        // Parity flip on the first payload byte
        make_msg(7'h41, 3, -1, 7'h00, 0);
        run_msg("t5", PRE_LEN + 1, 0, 0, 1'b0);
`ifdef PARITY_CHECK_EN
        check("t5_perr", parity_err, 1);
        check("t5_b0_flag", g0[7], 1);
        check("t5_b1_flag", g1[7], 0);
`else
        check("t5_perr", parity_err, 0);
        check("t5_b0", g0, 8'h48);
`endif

        // Early last on the first preamble byte, then a clean restart
        make_msg(7'h41, 3, -1, 7'h00, -1);
        run_msg("t6", 0, 0, 0, 1'b0);
        check("t6_error", error, 1);
        run_msg("t6_restart", PRE_LEN + 1, 0, 0, 1'b0);
        check("t6_restart_error", error, 0);

        // Last flag on the final preamble byte
        run_msg("last_pre_end", PRE_LEN - 1, 0, 0, 1'b0);

        // Zero seed: all taps fit, lowest index wins
        make_msg(7'h00, 5, -1, 7'h00, -1);
        run_msg("zero_seed", PRE_LEN + 1, 0, 0, 1'b0);
        check("zero_seed_tap", tap_idx, 0);

        // Asynchronous reset mid-payload with a byte pending
        cur_tag = "t1";
        make_msg(7'h41, 3, -1, 7'h00, -1);
        got_q.delete();
        done_cnt   = 0;
        prev_stall = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        feed(PRE_LEN + 1, -1, 3, 0, 1'b0);
        @(negedge clk);
        check("pend_valid", out_valid, 1);
        check("pend_data", out_data, 8'h48);
        check("pend_tap", tap_idx, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_tap", tap_idx, 0);
        check("rst_done", done, 0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        prev_stall = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", in_ready, 0);
        $display("msg t1: reset applied mid-payload");

        // Randomized messages
        for (int n = 0; n < 40; n++) begin
            r_len = $urandom_range(1, 6);
            r_pci = -1;
            r_px  = 7'h00;
            r_pfi = -1;
            plain_q.delete();
            for (int i = 0; i < r_len; i++) plain_q.push_back(8'($urandom_range(0, 127)));
            if ($urandom_range(0, 5) == 0) begin
                r_pci = $urandom_range(0, PRE_LEN - 1);
                r_px  = 7'($urandom_range(1, 127));
            end
            if ($urandom_range(0, 3) == 0) r_pfi = $urandom_range(0, r_len - 1);
            make_msg(7'($urandom_range(0, 127)), $urandom_range(0, 7), r_pci, r_px, r_pfi);
            r_lp = PRE_LEN + r_len - 1;
            if ($urandom_range(0, 7) == 0) r_lp = $urandom_range(0, r_lp - 1);
            run_msg($sformatf("rnd%0d", n), r_lp, $urandom_range(0, 2), $urandom_range(1, 4),
                    1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
